dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the SISC word-addressed data memory (`dm`). It accepts load/store requests from two requesters (port 0: the SISC core's memory stage; port 1: a debug/DMA loader) and serialises them onto the single `dm` port. It generates the `dm_we` pulse whose falling edge commits a write, and returns read data with a one-cycle `ack`. It sits between the requesters and `dm`, and is the only block that drives `dm` inputs.

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arb_pick.sv | 28 ++
 rtl/dm_arbiter.sv | 136 +++++++++++++
 tb/tb_dm_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter block.
package dm_arb_pkg;

    localparam int unsigned DM_AW_DEF = 16;
    localparam int unsigned DM_DW_DEF = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select for the two dm requesters.
// DM_ARB_RR_EN: round-robin on the last-granted port; otherwise port 0 has fixed priority.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef DM_ARB_RR_EN
    input  logic last,
`endif
    output logic grant_c
);

    always_comb begin
        grant_c = PORT0;
`ifdef DM_ARB_RR_EN
        // on a tie, the port that was not granted last time wins
        if (req1 && (!req0 || (last == PORT0))) begin
            grant_c = PORT1;
        end
`else
        if (req1 && !req0) begin
            grant_c = PORT1;
        end
`endif
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the SISC data memory: serialises loads and stores onto dm.
// DM_ARB_RR_EN selects round-robin arbitration (default build: fixed priority to port 0).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW = DM_AW_DEF,
    parameter int unsigned DW = DM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst_f,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,

    output logic [AW-1:0] dm_read_addr,
    output logic [AW-1:0] dm_write_addr,
    output logic [DW-1:0] dm_write_data,
    output logic          dm_we,
    input  logic [DW-1:0] dm_read_data,

    output logic          busy
);

    state_t        state_q;
    state_t        state_d;
    logic          port_q;
    logic          grant_c;
    logic          accept_c;
    logic          win_we_c;
    logic [AW-1:0] win_addr_c;
    logic [DW-1:0] win_wdata_c;
`ifdef DM_ARB_RR_EN
    logic          last_q;
`endif

    dm_arb_pick u_pick (
        .req0    (p0_req),
        .req1    (p1_req),
`ifdef DM_ARB_RR_EN
        .last    (last_q),
`endif
        .grant_c (grant_c)
    );

    // Winner's request fields
    always_comb begin
        win_we_c    = p0_we;
        win_addr_c  = p0_addr;
        win_wdata_c = p0_wdata;
        if (grant_c == PORT1) begin
            win_we_c    = p1_we;
            win_addr_c  = p1_addr;
            win_wdata_c = p1_wdata;
        end
    end

    // Next-state logic; requests are only accepted from IDLE
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    accept_c = 1'b1;
                    state_d  = win_we_c ? WR : RD;
                end
            end
            RD:      state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched transaction, dm drive and requester responses
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            port_q        <= PORT0;
            busy          <= 1'b0;
            dm_we         <= 1'b0;
            dm_read_addr  <= '0;
            dm_write_addr <= '0;
            dm_write_data <= '0;
            p0_ack        <= 1'b0;
            p1_ack        <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
`ifdef DM_ARB_RR_EN
            last_q        <= PORT1;
`endif
        end else begin
            busy   <= (state_d != IDLE);
            dm_we  <= (state_d == WR);
            p0_ack <= (state_d == DONE) && (port_q == PORT0);
            p1_ack <= (state_d == DONE) && (port_q == PORT1);
            if (accept_c) begin
                port_q       <= grant_c;
                dm_read_addr <= win_addr_c;
                if (win_we_c) begin
                    dm_write_addr <= win_addr_c;
                    dm_write_data <= win_wdata_c;
                end
`ifdef DM_ARB_RR_EN
                last_q <= grant_c;
`endif
            end
            if (state_q == RD) begin
                if (port_q == PORT0) begin
                    p0_rdata <= dm_read_data;
                end else begin
                    p1_rdata <= dm_read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural dm that commits on dm_we fall.
module tb_dm_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_f;
    logic          p0_req, p0_we, p0_ack;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_ack;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] dm_read_addr, dm_write_addr;
    logic [DW-1:0] dm_write_data, dm_read_data;
    logic          dm_we, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .p0_req        (p0_req),
        .p0_we         (p0_we),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_ack        (p0_ack),
        .p0_rdata      (p0_rdata),
        .p1_req        (p1_req),
        .p1_we         (p1_we),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_ack        (p1_ack),
        .p1_rdata      (p1_rdata),
        .dm_read_addr  (dm_read_addr),
        .dm_write_addr (dm_write_addr),
        .dm_write_data (dm_write_data),
        .dm_we         (dm_we),
        .dm_read_data  (dm_read_data),
        .busy          (busy)
    );

    // dm model: async read; write address/data sampled mid-cycle while dm_we is high
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] sh_a = '0;
    logic [DW-1:0] sh_d = '0;
    assign dm_read_data = mem[dm_read_addr];
    always @(negedge clk) if (dm_we) begin
        sh_a <= dm_write_addr;
        sh_d <= dm_write_data;
    end
    always @(negedge dm_we) mem[sh_a] <= sh_d;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [DW-1:0] gseq [4];
        logic [DW-1:0] exp_g;
        int            nack;
        int            last_c;

        rst_f = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_dm_we", dm_we, 1'b0);
        chk1("rst_p0_ack", p0_ack, 1'b0);
        chk1("rst_p1_ack", p1_ack, 1'b0);
        chkw("rst_p0_rdata", p0_rdata, 32'h0);
        chkw("rst_rd_addr", DW'(dm_read_addr), 32'h0);

        // P0 store 0x0010 <- DEADBEEF
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk1("st_we_t0", dm_we, 1'b1);
        chk1("st_busy_t0", busy, 1'b1);
        chk1("st_ack_early", p0_ack, 1'b0);
        chkw("st_waddr", DW'(dm_write_addr), 32'h0000_0010);
        chkw("st_wdata", dm_write_data, 32'hDEADBEEF);
        @(negedge clk);
        chk1("st_we_fall", dm_we, 1'b0);
        chk1("st_p0_ack", p0_ack, 1'b1);
        chk1("st_p1_noack", p1_ack, 1'b0);
        chkw("st_mem", mem[16'h0010], 32'hDEADBEEF);
        p0_req = 1'b0;
        @(negedge clk);
        chk1("st_ack_drop", p0_ack, 1'b0);
        chk1("st_idle", busy, 1'b0);

        // P0 load 0x0010 right after the store
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
        @(negedge clk);
        chk1("ld_busy", busy, 1'b1);
        chk1("ld_no_we", dm_we, 1'b0);
        chkw("ld_raddr", DW'(dm_read_addr), 32'h0000_0010);
        @(negedge clk);
        chk1("ld_p0_ack", p0_ack, 1'b1);
        chkw("ld_p0_rdata", p0_rdata, 32'hDEADBEEF);
        p0_req = 1'b0;
        @(negedge clk);
        chk1("ld_ack_drop", p0_ack, 1'b0);
        chkw("ld_rdata_hold", p0_rdata, 32'hDEADBEEF);

        // P1 store with req held through ack: no accept in DONE
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0030; p1_wdata = 32'h12345678;
        @(negedge clk);
        chk1("p1st_we", dm_we, 1'b1);
        @(negedge clk);
        chk1("p1st_ack", p1_ack, 1'b1);
        chk1("p1st_p0_noack", p0_ack, 1'b0);
        chkw("p1st_mem1", mem[16'h0030], 32'h12345678);
        p1_wdata = 32'h55AA55AA;
        @(negedge clk);
        chk1("p1st_no_done_accept", busy, 1'b0);
        chk1("p1st_we_idle", dm_we, 1'b0);
        chk1("p1st_ack_once", p1_ack, 1'b0);
        @(negedge clk);
        chk1("p1st_reaccept", dm_we, 1'b1);
        chkw("p1st_wdata2", dm_write_data, 32'h55AA55AA);
        @(negedge clk);
        chk1("p1st_ack2", p1_ack, 1'b1);
        p1_req = 1'b0;
        @(negedge clk);
        chkw("p1st_mem2", mem[16'h0030], 32'h55AA55AA);
        chk1("p1st_idle", busy, 1'b0);

        // Simultaneous loads, four back-to-back grants
        mem[16'h0020] = 32'hA0A0_0001;
        mem[16'h0021] = 32'hB1B1_0002;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0020;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0021;
        nack = 0;
        last_c = -1;
        for (int c = 0; c < 20 && nack < 4; c++) begin
            @(negedge clk);
            chk1("dual_ack", p0_ack & p1_ack, 1'b0);
            if (p0_ack || p1_ack) begin
                chkw("ack_spacing", DW'(c), DW'(1 + 3 * nack));
                last_c = c;
                gseq[nack] = p1_ack ? 32'd1 : 32'd0;
                if (p0_ack) chkw("rr_p0_rdata", p0_rdata, 32'hA0A0_0001);
                else        chkw("rr_p1_rdata", p1_rdata, 32'hB1B1_0002);
                nack++;
                if (nack == 4) begin
                    p0_req = 1'b0;
                    p1_req = 1'b0;
                end
            end
        end
        chkw("rr_ack_count", DW'(nack), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_RR_EN
            exp_g = DW'(i % 2);
`else
            exp_g = 32'd0;
`endif
            if (i < nack) chkw($sformatf("grant_%0d", i), gseq[i], exp_g);
        end
        if (last_c >= 0) begin
            @(negedge clk);
            chk1("rr_idle", busy, 1'b0);
        end

        // P1 load from unwritten 0xFFF0: rdata follows whatever dm returns
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'hFFF0;
        @(negedge clk);
        chk1("unw_busy", busy, 1'b1);
        @(negedge clk);
        chk1("unw_ack", p1_ack, 1'b1);
        chkw("unw_rdata", p1_rdata, mem[16'hFFF0]);
        p1_req = 1'b0;
        @(negedge clk);
        chk1("unw_idle", busy, 1'b0);
        chk1("unw_ack_drop", p1_ack, 1'b0);

        // Reset asserted mid-WR: write commits, no ack, everything back to reset values
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0040; p0_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk1("mrst_we_before", dm_we, 1'b1);
        #2;
        rst_f = 1'b0;
        p0_req = 1'b0;
        #1;
        chk1("mrst_we", dm_we, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_p0_ack", p0_ack, 1'b0);
        chkw("mrst_p0_rdata", p0_rdata, 32'h0);
        chkw("mrst_p1_rdata", p1_rdata, 32'h0);
        chkw("mrst_waddr", DW'(dm_write_addr), 32'h0);
        chkw("mrst_wdata", dm_write_data, 32'h0);
        chkw("mrst_raddr", DW'(dm_read_addr), 32'h0);
        chkw("mrst_commit", mem[16'h0040], 32'hCAFEF00D);
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        chk1("mrst_no_ack", p0_ack, 1'b0);
        chk1("mrst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
